// File: rtl/ysyx_23060111_mem_resp.sv
// Word-organised SRAM responder for the LSU valid/ready port: one transaction
// in flight, fixed LAT wait cycles, registered response held until accepted.
module ysyx_23060111_mem_resp #(
    parameter int          DEPTH = 1024,
    parameter int          LAT   = 2,
    parameter logic [31:0] BASE  = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] SPAN     = 32'(DEPTH * 4);
    localparam logic [3:0]  CNT_INIT = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            wen_q, wen_d;
    logic            err_q, err_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            rsp_err_q, rsp_err_d;

    logic [31:0]     mem [DEPTH];

    logic [31:0]     off_s;
    logic            dec_ok_s;
    logic [AW-1:0]   dec_idx_s;
    logic            hs_s;
    logic            mem_we_s;
    logic            load_rsp_s;
    logic            rd_wen_s;
    logic            rd_err_s;
    logic [AW-1:0]   rd_idx_s;

    assign off_s     = req_addr - BASE;
    assign dec_ok_s  = (req_addr >= BASE) && (off_s < SPAN) && (off_s[1:0] == 2'b00);
    assign dec_idx_s = off_s[AW+1:2];

    assign req_ready = (state_q == S_IDLE) && !rst;
    assign hs_s      = req_valid && req_ready;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = rsp_err_q;

    // Next-state, request capture and response loading.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wen_d      = wen_q;
        err_d      = err_q;
        idx_d      = idx_q;
        rdata_d    = rdata_q;
        rsp_err_d  = rsp_err_q;
        mem_we_s   = 1'b0;
        load_rsp_s = 1'b0;
        rd_wen_s   = wen_q;
        rd_err_s   = err_q;
        rd_idx_s   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (hs_s) begin
                    wen_d    = req_wen;
                    err_d    = !dec_ok_s;
                    idx_d    = dec_idx_s;
                    mem_we_s = req_wen && dec_ok_s;
                    if (LAT == 0) begin
                        // Zero latency: the response is built straight from the live request.
                        state_d    = S_RESP;
                        load_rsp_s = 1'b1;
                        rd_wen_s   = req_wen;
                        rd_err_s   = !dec_ok_s;
                        rd_idx_s   = dec_idx_s;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = S_RESP;
                    load_rsp_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d   = S_IDLE;
                    rdata_d   = 32'd0;
                    rsp_err_d = 1'b0;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (load_rsp_s) begin
            rdata_d   = (rd_wen_s || rd_err_s) ? 32'd0 : mem[rd_idx_s];
            rsp_err_d = rd_err_s;
        end else begin
            rsp_err_d = rsp_err_d;
        end
    end

    // Control and response registers; array contents are deliberately not reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            wen_q     <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            rdata_q   <= 32'd0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wen_q     <= wen_d;
            err_q     <= err_d;
            idx_q     <= idx_d;
            rdata_q   <= rdata_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    // Byte-strobed write committed at the acceptance edge.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (req_wmask[i]) begin
                    mem[dec_idx_s][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: doc/ysyx_23060111_mem_resp.md
Name: ysyx_23060111_mem_resp

Overview:
- Memory responder (slave) for the core's load/store port: the target end of a valid/ready request/response protocol.
- Replaces the zero-latency combinational memory model with a word-organised SRAM that has programmable latency and error reporting.
- Lets the LSU initiator be brought up against a realistic, stalling memory.
- Sits between the core's memory port and the top level; one outstanding transaction at a time.

Parameters:
- DEPTH, 1024, number of 32-bit words stored.
- LAT, 2, extra wait cycles between request acceptance and response valid (0..15).
- BASE, 32'h8000_0000, byte address mapped to word 0.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request.
- req_wen  input  1  1 = write, 0 = read.
- req_addr  input  32  byte address.
- req_wdata  input  32  write data.
- req_wmask  input  4  byte strobes; bit i enables byte i.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  initiator accepts the response.
- rsp_rdata  output  32  read data; 0 for writes and errors.
- rsp_err  output  1  access error flag.

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst).
- While rst is high:
  - State is IDLE; req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Latency counter is 0.
  - Array contents are not reset and are retained across reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1 (combinational from state, gated by !rst).
  - A handshake is req_valid && req_ready at rising edge N.
  - At the handshake, the request is latched (wen, addr, wdata, wmask).
  - Go to RESP if LAT==0; otherwise go to WAIT with cnt=LAT-1.
- WAIT:
  - req_ready=0.
  - If cnt==0, go to RESP on the next edge; otherwise cnt decrements.
  - Net effect: rsp_valid is first high in the cycle after edge N+LAT.
- RESP:
  - rsp_valid=1; req_ready=0.
  - rsp_rdata and rsp_err are registered and held stable until rsp_ready is sampled high.
  - On the edge with rsp_ready=1, go to IDLE; rsp_valid=0 next cycle.
  - Minimum issue interval is LAT+2 cycles; there is no back-to-back overlap.
- Address decode:
  - off = req_addr - BASE (32-bit unsigned).
  - Valid iff req_addr >= BASE, off < DEPTH*4, and off[1:0]==0.
  - Word index = off[31:2], truncated to clog2(DEPTH) bits.
- Write:
  - Committed at the acceptance edge N; only the bytes whose wmask bit is 1 are updated.
  - wmask=0 is legal: no change, no error.
  - Response: rdata=0, err=0.
- Read:
  - Data is sampled from the array at the edge entering RESP.
  - It therefore reflects all writes committed earlier.
- Invalid address:
  - No array update; response has rdata=0, err=1.
  - The latency is the same as for a valid access.
- Input behaviour:
  - req_* inputs are ignored outside IDLE; changes after acceptance have no effect.
  - rsp_ready is ignored outside RESP; an early rsp_ready does not shorten latency.
- Reset mid-operation:
  - A pending transaction is dropped and no response is issued.
  - A write already accepted stays committed.

Test Plan:
- Reset then idle, LAT=2: rst high for 3 cycles -> req_ready=0, rsp_valid=0 throughout; after release req_ready=1, rsp_valid=0.
- Write then read, LAT=2:
  - Write addr 0x8000_0010, data 0xDEADBEEF, mask 4'hF accepted at edge N -> rsp_valid high after edge N+2, err=0, rdata=0.
  - Subsequent read of the same address -> rdata=0xDEADBEEF, err=0.
- Byte mask: prior word 0xDEADBEEF; write data 0x11223344, mask 4'b0101 -> read returns 0xDE22BE44.
- Errors:
  - Read 0x7FFF_FFFC -> err=1, rdata=0.
  - Read BASE+DEPTH*4 -> err=1.
  - Write 0x8000_0002 -> err=1; the word at 0x8000_0000 is unchanged.
- Backpressure, LAT=0:
  - Hold rsp_ready=0 for 5 cycles -> rsp_valid stays 1, rdata/err stable, req_ready stays 0.
  - Assert rsp_ready -> req_ready returns to 1 the following cycle.
- Reset in WAIT:
  - Assert rst one cycle after an accepted read -> no rsp_valid ever appears for that read.
  - Assert rst after an accepted write -> a later read returns the written data.
